// File: rtl/demux_1_2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with per-channel beat counters.
// Optional round-robin steering is built when DEMUX_RR_EN is defined.
module demux_1_2_stream #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     d,
  input  logic                 d_valid,
  output logic                 d_ready,
  input  logic                 s,
`ifdef DEMUX_RR_EN
  input  logic                 rr,
`endif
  output logic [WIDTH-1:0]     a,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [WIDTH-1:0]     b,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [CNT_WIDTH-1:0] a_cnt,
  output logic [CNT_WIDTH-1:0] b_cnt
);

  logic tgt;
  logic accept;
  logic load_a, load_b;
  logic drain_a, drain_b;

`ifdef DEMUX_RR_EN
  logic ptr;

  // ptr = 0 selects channel A; it only advances on accepted beats in RR mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (accept && rr)
      ptr <= ~ptr;
  end

  assign tgt = rr ? ptr : s;
`else
  assign tgt = s;
`endif

  // Ready depends only on the target channel's state, never on d_valid.
  assign d_ready = tgt ? (!b_valid || b_ready) : (!a_valid || a_ready);
  assign accept  = d_valid && d_ready;
  assign load_a  = accept && !tgt;
  assign load_b  = accept && tgt;
  assign drain_a = a_valid && a_ready;
  assign drain_b = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      a_valid <= 1'b0;
      a_cnt   <= '0;
    end else begin
      a_valid <= load_a || (a_valid && !a_ready);
      if (load_a)
        a <= d;
      if (drain_a)
        a_cnt <= a_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b       <= '0;
      b_valid <= 1'b0;
      b_cnt   <= '0;
    end else begin
      b_valid <= load_b || (b_valid && !b_ready);
      if (load_b)
        b <= d;
      if (drain_b)
        b_cnt <= b_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
